// File: rtl/mem_row_streamer.sv
// Row read sequencer: walks a rows x width tile, one scratchpad read per row, buffers rows for the feeder.
// Build option: define ROW_ZERO_PAD_EN to zero lanes at or beyond the latched width when a row is captured.
module mem_row_streamer #(
  parameter int NUM_RAMS   = 16,
  parameter int D_WID      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [31:0]               cfg_base_addr,
  input  logic [31:0]               cfg_stride,
  input  logic [CNT_W-1:0]          cfg_rows,
  input  logic [4:0]                cfg_width,
  input  logic                      sys_bus_busy,
  output logic                      interface_en,
  output logic                      interface_rdwr,
  output logic [4:0]                interface_control,
  output logic [31:0]               interface_addr,
  input  logic [NUM_RAMS*D_WID-1:0] bank_dout,
  output logic [NUM_RAMS*D_WID-1:0] row_data,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic                      row_last,
  output logic                      busy,
  output logic                      done
);

  localparam int DW    = NUM_RAMS * D_WID;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | issuing row reads
  // DRAIN | all rows issued, waiting for buffer to empty
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [31:0]      addr_acc;
  logic [31:0]      stride;
  logic [CNT_W-1:0] rows;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] push_idx;
  logic [4:0]       width;
  logic             inflight;

  logic [DW-1:0]    fifo_data [FIFO_DEPTH];
  logic             fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_cnt;

  logic             issue;
  logic             push;
  logic             pop;
  logic [DW-1:0]    capt;
  logic [4:0]       width_eff;

  // Buffer space is reserved for the read already in flight so a push can never overflow.
  assign issue = (state == RUN) && (issued < rows) && !sys_bus_busy &&
                 ((fifo_cnt + {{PTR_W{1'b0}}, inflight}) < DEPTH_C);
  assign push  = inflight;
  assign pop   = row_valid && row_ready;

  assign interface_en      = issue;
  assign interface_rdwr    = 1'b0;
  assign interface_control = width;
  assign interface_addr    = addr_acc;

  assign row_valid = (fifo_cnt != '0);
  assign row_data  = row_valid ? fifo_data[rd_ptr] : '0;
  assign row_last  = row_valid && fifo_last[rd_ptr];

  assign width_eff = ((cfg_width == 5'd0) || (cfg_width > 5'(NUM_RAMS))) ? 5'(NUM_RAMS) : cfg_width;

  always_comb begin
    capt = bank_dout;
`ifdef ROW_ZERO_PAD_EN
    for (int i = 0; i < NUM_RAMS; i++) begin
      if (i >= int'(width)) capt[i*D_WID +: D_WID] = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= capt;
      fifo_last[wr_ptr] <= (push_idx == rows - CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_acc <= '0;
      stride   <= '0;
      rows     <= '0;
      issued   <= '0;
      push_idx <= '0;
      width    <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        addr_acc <= addr_acc + stride;
        issued   <= issued + CNT_W'(1);
      end
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        push_idx <= push_idx + CNT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);

      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_rows != '0) begin
              state    <= RUN;
              busy     <= 1'b1;
              addr_acc <= cfg_base_addr;
              stride   <= cfg_stride;
              rows     <= cfg_rows;
              width    <= width_eff;
              issued   <= '0;
              push_idx <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issued == rows) state <= DRAIN;
        end
        DRAIN: begin
          // Finish on the edge that pops the final row.
          if (!inflight && ((fifo_cnt == '0) || ((fifo_cnt == (PTR_W+1)'(1)) && pop))) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_row_streamer.sv
// Directed scoreboard bench for mem_row_streamer: expected addresses/rows queued at launch, checked on issue/pop.
module tb_mem_row_streamer;

  localparam int W = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   cfg_base_addr = '0;
  logic [31:0]   cfg_stride = '0;
  logic [15:0]   cfg_rows = '0;
  logic [4:0]    cfg_width = '0;
  logic          sys_bus_busy = 1'b0;
  logic          interface_en;
  logic          interface_rdwr;
  logic [4:0]    interface_control;
  logic [31:0]   interface_addr;
  logic [W-1:0]  bank_dout;
  logic [W-1:0]  row_data;
  logic          row_valid;
  logic          row_ready = 1'b0;
  logic          row_last;
  logic          busy;
  logic          done;

  mem_row_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_stride(cfg_stride),
    .cfg_rows(cfg_rows), .cfg_width(cfg_width), .sys_bus_busy(sys_bus_busy),
    .interface_en(interface_en), .interface_rdwr(interface_rdwr),
    .interface_control(interface_control), .interface_addr(interface_addr),
    .bank_dout(bank_dout), .row_data(row_data), .row_valid(row_valid),
    .row_ready(row_ready), .row_last(row_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en_count = 0;
  int beat_count = 0;
  int done_count = 0;
  int last_pop_cyc = 0;
  int last_en_cyc = 0;
  logic [4:0] exp_ctrl = '0;

  logic [31:0]  exp_addr_q[$];
  logic [W-1:0] exp_data_q[$];
  logic         exp_last_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] mem_word(input logic [31:0] a);
    logic [W-1:0] w;
    for (int i = 0; i < 16; i++) w[i*8 +: 8] = (a[7:0] ^ 8'hC3) + 8'(i * 29) + a[15:8];
    return w;
  endfunction

  function automatic logic [W-1:0] exp_row(input logic [31:0] a, input logic [4:0] wd);
    logic [W-1:0] r;
    r = mem_word(a);
`ifdef ROW_ZERO_PAD_EN
    for (int i = 0; i < 16; i++) if (i >= int'(wd)) r[i*8 +: 8] = 8'h00;
`endif
    return r;
  endfunction

  // Scratchpad model: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (interface_en === 1'b1) bank_dout <= mem_word(interface_addr);
    else bank_dout <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (interface_en) begin
        en_count++;
        last_en_cyc = cyc;
        chk("issue_expected", W'(exp_addr_q.size() > 0), W'(1));
        if (exp_addr_q.size() > 0) chk("addr", W'(interface_addr), W'(exp_addr_q.pop_front()));
        chk("ctrl", W'(interface_control), W'(exp_ctrl));
        chk("rdwr", W'(interface_rdwr), W'(0));
        chk("no_issue_while_bus_busy", W'(sys_bus_busy), W'(0));
      end
      if (row_valid && row_ready) begin
        beat_count++;
        chk("beat_expected", W'(exp_data_q.size() > 0), W'(1));
        if (exp_data_q.size() > 0) begin
          logic el;
          el = exp_last_q.pop_front();
          chk("row_data", row_data, exp_data_q.pop_front());
          chk("row_last", W'(row_last), W'(el));
          if (el) last_pop_cyc = cyc;
        end
      end
      if (!row_valid) chk("row_data_zero_empty", row_data, '0);
      if (done) done_count++;
    end
  end

  task automatic launch(input logic [31:0] base, input logic [31:0] str, input int nrows,
                        input logic [4:0] wd, input bit record, output int s);
    logic [4:0] ew;
    ew = ((wd == 5'd0) || (wd > 5'd16)) ? 5'd16 : wd;
    cfg_base_addr = base;
    cfg_stride    = str;
    cfg_rows      = 16'(nrows);
    cfg_width     = wd;
    start         = 1'b1;
    if (record) begin
      exp_ctrl = ew;
      for (int i = 0; i < nrows; i++) begin
        exp_addr_q.push_back(base + 32'(i) * str);
        exp_data_q.push_back(exp_row(base + 32'(i) * str, ew));
        exp_last_q.push_back(i == nrows - 1);
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input string tag, output int dc);
    dc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
    end
    chk({tag, "_done_seen"}, W'(dc >= 0), W'(1));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, W'(done), W'(0));
    chk({tag, "_idle_after_done"}, W'(busy), W'(0));
    chk({tag, "_queues_empty"}, W'(exp_addr_q.size() + exp_data_q.size()), W'(0));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_en"}, W'(interface_en), W'(0));
    chk({tag, "_addr"}, W'(interface_addr), W'(0));
    chk({tag, "_ctrl"}, W'(interface_control), W'(0));
    chk({tag, "_row_data"}, row_data, '0);
    chk({tag, "_row_valid"}, W'(row_valid), W'(0));
    chk({tag, "_row_last"}, W'(row_last), W'(0));
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_done"}, W'(done), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, dc, e0, b0, d0, base_lat, dn0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 4 rows, consecutive issue, last flagged, done after last pop
    row_ready = 1'b1;
    e0 = en_count; b0 = beat_count;
    launch(32'h40, 32'd16, 4, 5'd16, 1'b1, s);
    @(negedge clk);
    chk("t1_first_issue_latency", W'(interface_en), W'(1));
    chk("t1_busy", W'(busy), W'(1));
    wait_done("t1", dc);
    chk("t1_consecutive", W'(last_en_cyc - s), W'(3));
    chk("t1_issue_count", W'(en_count - e0), W'(4));
    chk("t1_beats", W'(beat_count - b0), W'(4));
    chk("t1_done_after_last_pop", W'(dc - last_pop_cyc), W'(1));

    // narrow rows, odd base
    launch(32'h13, 32'h20, 3, 5'd5, 1'b1, s);
    wait_done("t2", dc);

    // width 0 means full row
    launch(32'h1000, 32'h10, 2, 5'd0, 1'b1, s);
    wait_done("t2b", dc);

    // consumer stalled: only FIFO_DEPTH reads go out
    row_ready = 1'b0;
    e0 = en_count; b0 = beat_count;
    launch(32'h100, 32'h10, 8, 5'd16, 1'b1, s);
    repeat (12) @(negedge clk);
    chk("t3_stall_issue_count", W'(en_count - e0), W'(4));
    chk("t3_head_valid", W'(row_valid), W'(1));
    chk("t3_head_data", row_data, exp_data_q[0]);
    @(posedge clk);
    #1 begin
      cfg_base_addr = 32'h999; cfg_rows = 16'd3; start = 1'b1;
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("t3_head_held", row_data, exp_data_q[0]);
    chk("t3_still_stalled", W'(en_count - e0), W'(4));
    @(posedge clk);
    #1 row_ready = 1'b1;
    wait_done("t3", dc);
    chk("t3_issue_count", W'(en_count - e0), W'(8));
    chk("t3_beats", W'(beat_count - b0), W'(8));
    chk("t3_done_after_last_pop", W'(dc - last_pop_cyc), W'(1));

    // bus busy during job cycles 2-4 delays completion by 3
    launch(32'h200, 32'h40, 6, 5'd16, 1'b1, s);
    wait_done("t4a", dc);
    base_lat = dc - s;
    e0 = en_count;
    launch(32'h200, 32'h40, 6, 5'd16, 1'b1, s);
    @(posedge clk);
    #1 sys_bus_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 sys_bus_busy = 1'b0;
    wait_done("t4b", dc);
    chk("t4_done_delay", W'((dc - s) - base_lat), W'(3));
    chk("t4_issue_count", W'(en_count - e0), W'(6));

    // zero-row job
    e0 = en_count;
    launch(32'h500, 32'h10, 0, 5'd16, 1'b1, s);
    @(negedge clk);
    chk("t5_done_pulse", W'(done), W'(1));
    chk("t5_not_busy", W'(busy), W'(0));
    @(negedge clk);
    chk("t5_done_cleared", W'(done), W'(0));
    chk("t5_no_issue", W'(en_count - e0), W'(0));

    // reset mid-job
    row_ready = 1'b0;
    e0 = en_count;
    launch(32'h300, 32'd8, 5, 5'd16, 1'b1, s);
    for (int k = 0; k < 50; k++) begin
      if (en_count >= e0 + 2) break;
      @(negedge clk);
    end
    chk("t6_two_issued", W'(en_count >= e0 + 2), W'(1));
    dn0 = done_count;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("t6_reset");
    exp_addr_q.delete(); exp_data_q.delete(); exp_last_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_done", W'(done_count - dn0), W'(0));
    row_ready = 1'b1;
    b0 = beat_count;
    launch(32'h700, 32'h30, 2, 5'd7, 1'b1, s);
    wait_done("t6_restart", dc);
    chk("t6_restart_beats", W'(beat_count - b0), W'(2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
